// File: rtl/vx_norm_shift.sv
// Two-stage normalizing shifter: S0 registers the input beat, S1 registers the shifted value and adjusted exponent.
// Optional zero-beat performance counter is enabled by defining NORM_PERF_EN.
module vx_norm_shift #(
  parameter  int N    = 32,
  parameter  int EXPW = 8,
  parameter  int TAGW = 1,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic [N-1:0]    data_in,
  input  logic [LOGN-1:0] lzc_in,
  input  logic            lzc_valid_in,
  input  logic [EXPW-1:0] exp_in,
  input  logic [TAGW-1:0] tag_in,
  output logic            valid_out,
  input  logic            ready_out,
  output logic [N-1:0]    data_out,
  output logic [EXPW-1:0] exp_out,
  output logic [LOGN-1:0] shift_out,
  output logic            zero_out,
  output logic            underflow_out,
  output logic [TAGW-1:0] tag_out
`ifdef NORM_PERF_EN
  ,
  output logic [31:0]     perf_zero_count
`endif
);

  // Common width wide enough for both the exponent and the shift count.
  localparam int             CW  = ((EXPW > LOGN) ? EXPW : LOGN) + 1;
  localparam logic [LOGN:0]  N_W = (LOGN + 1)'(N);

  logic            s0_valid_q, s0_valid_d;
  logic [N-1:0]    s0_data_q, s0_data_d;
  logic [LOGN-1:0] s0_lzc_q, s0_lzc_d;
  logic            s0_lzv_q, s0_lzv_d;
  logic [EXPW-1:0] s0_exp_q, s0_exp_d;
  logic [TAGW-1:0] s0_tag_q, s0_tag_d;

  logic            s1_valid_q, s1_valid_d;
  logic [N-1:0]    s1_data_q, s1_data_d;
  logic [EXPW-1:0] s1_exp_q, s1_exp_d;
  logic [LOGN-1:0] s1_shift_q, s1_shift_d;
  logic            s1_zero_q, s1_zero_d;
  logic            s1_uf_q, s1_uf_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;

  logic            s1_adv_s;
  logic            in_xfer_s;
  logic [CW-1:0]   exp_w_s, lzc_w_s;
  logic [N-1:0]    nrm_data_s;
  logic [EXPW-1:0] nrm_exp_s;
  logic [LOGN-1:0] nrm_shift_s;
  logic            nrm_zero_s, nrm_uf_s;

  // Handshake and S0 capture.
  always_comb begin
    s1_adv_s   = !s1_valid_q || ready_out;
    ready_in   = !reset && (!s0_valid_q || s1_adv_s);
    in_xfer_s  = valid_in && ready_in;
    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    s0_lzc_d   = s0_lzc_q;
    s0_lzv_d   = s0_lzv_q;
    s0_exp_d   = s0_exp_q;
    s0_tag_d   = s0_tag_q;
    if (ready_in) begin
      s0_valid_d = valid_in;
    end else begin
      s0_valid_d = s0_valid_q;
    end
    if (in_xfer_s) begin
      s0_data_d = data_in;
      s0_lzc_d  = lzc_in;
      s0_lzv_d  = lzc_valid_in;
      s0_exp_d  = exp_in;
      s0_tag_d  = tag_in;
    end else begin
      s0_data_d = s0_data_q;
    end
  end

  // Normalization of the S0 beat; a zero beat bypasses the shift entirely.
  always_comb begin
    exp_w_s     = CW'(s0_exp_q);
    lzc_w_s     = CW'(s0_lzc_q);
    nrm_data_s  = '0;
    nrm_exp_s   = s0_exp_q;
    nrm_shift_s = '0;
    nrm_zero_s  = 1'b1;
    nrm_uf_s    = 1'b0;
    if (s0_lzv_q) begin
      // Shift counts at or beyond N (non-power-of-two N) flush the value.
      if ({1'b0, s0_lzc_q} >= N_W) begin
        nrm_data_s = '0;
      end else begin
        nrm_data_s = s0_data_q << s0_lzc_q;
      end
      nrm_exp_s   = EXPW'(exp_w_s - lzc_w_s);
      nrm_shift_s = s0_lzc_q;
      nrm_zero_s  = 1'b0;
      nrm_uf_s    = (lzc_w_s > exp_w_s);
    end else begin
      nrm_zero_s = 1'b1;
    end
  end

  // S1 capture; holds every field while the downstream stalls.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_exp_d   = s1_exp_q;
    s1_shift_d = s1_shift_q;
    s1_zero_d  = s1_zero_q;
    s1_uf_d    = s1_uf_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv_s) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        s1_data_d  = nrm_data_s;
        s1_exp_d   = nrm_exp_s;
        s1_shift_d = nrm_shift_s;
        s1_zero_d  = nrm_zero_s;
        s1_uf_d    = nrm_uf_s;
        s1_tag_d   = s0_tag_q;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_lzc_q   <= '0;
      s0_lzv_q   <= 1'b0;
      s0_exp_q   <= '0;
      s0_tag_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_shift_q <= '0;
      s1_zero_q  <= 1'b0;
      s1_uf_q    <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_lzc_q   <= s0_lzc_d;
      s0_lzv_q   <= s0_lzv_d;
      s0_exp_q   <= s0_exp_d;
      s0_tag_q   <= s0_tag_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_exp_q   <= s1_exp_d;
      s1_shift_q <= s1_shift_d;
      s1_zero_q  <= s1_zero_d;
      s1_uf_q    <= s1_uf_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign valid_out     = s1_valid_q;
  assign data_out      = s1_data_q;
  assign exp_out       = s1_exp_q;
  assign shift_out     = s1_shift_q;
  assign zero_out      = s1_zero_q;
  assign underflow_out = s1_uf_q;
  assign tag_out       = s1_tag_q;

`ifdef NORM_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of zero beats accepted at the input.
  always_comb begin
    perf_d = perf_q;
    if (in_xfer_s && !lzc_valid_in && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_zero_count = perf_q;
`endif

endmodule

// File: tb/tb_vx_norm_shift.sv
// Randomized and directed bench for vx_norm_shift (N=8, EXPW=8, TAGW=4) with a queue-based reference model.
module tb_vx_norm_shift;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [7:0] data_in = 8'd0;
  logic [2:0] lzc_in = 3'd0;
  logic       lzc_valid_in = 1'b0;
  logic [7:0] exp_in = 8'd0;
  logic [3:0] tag_in = 4'd0;
  logic       valid_out;
  logic       ready_out = 1'b0;
  logic [7:0] data_out;
  logic [7:0] exp_out;
  logic [2:0] shift_out;
  logic       zero_out;
  logic       underflow_out;
  logic [3:0] tag_out;
`ifdef NORM_PERF_EN
  logic [31:0] perf_zero_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int zero_acc = 0;
  logic [24:0] sb_q[$];

  vx_norm_shift #(.N(8), .EXPW(8), .TAGW(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .lzc_in(lzc_in), .lzc_valid_in(lzc_valid_in),
    .exp_in(exp_in), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .exp_out(exp_out), .shift_out(shift_out),
    .zero_out(zero_out), .underflow_out(underflow_out), .tag_out(tag_out)
`ifdef NORM_PERF_EN
    , .perf_zero_count(perf_zero_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {data, exp, shift, zero, underflow, tag}.
  function automatic logic [24:0] model(input logic [7:0] d, input logic [2:0] l,
                                        input logic lv, input logic [7:0] e, input logic [3:0] t);
    logic [7:0] od, oe;
    logic [2:0] os;
    logic       z, u;
    int         ex;
    if (!lv) begin
      od = 8'd0; oe = e; os = 3'd0; z = 1'b1; u = 1'b0;
    end else begin
      if (int'(l) >= 8) od = 8'd0;
      else od = 8'((int'(d) * (1 << int'(l))) % 256);
      ex = (int'(e) - int'(l) + 256) % 256;
      oe = 8'(ex);
      os = l;
      z  = 1'b0;
      u  = (int'(l) > int'(e));
    end
    return {od, oe, os, z, u, t};
  endfunction

  // One cycle starting at a negedge: drive, score transfers, advance to next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] l, input logic lv,
                      input logic [7:0] e, input logic [3:0] t, input logic rdy, output logic acc);
    valid_in = v; data_in = d; lzc_in = l; lzc_valid_in = lv; exp_in = e; tag_in = t;
    ready_out = rdy;
    #1;
    if (valid_out && ready_out) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_beat", 64'(tag_out), 64'hDEAD);
      end else begin
        check_eq("beat", 64'({data_out, exp_out, shift_out, zero_out, underflow_out, tag_out}),
                 64'(sb_q.pop_front()));
        n_pops++;
      end
    end
    acc = valid_in && ready_in;
    if (acc) begin
      sb_q.push_back(model(d, l, lv, e, t));
      if (!lv) zero_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    logic a;
    step(1'b0, 8'd0, 3'd0, 1'b0, 8'd0, 4'd0, rdy, a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b1;
    #1;
    check_eq("rst_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    sb_q.delete();
    zero_acc = 0;
    #1;
    check_eq("rst_valid_out", 64'(valid_out), 64'd0);
    check_eq("rst_fields", 64'({data_out, exp_out, shift_out, zero_out, underflow_out, tag_out}), 64'd0);
    check_eq("post_rst_ready", 64'(ready_in), 64'd1);
  endtask

  initial begin
    logic a;
    int   next_tag;
    int   pops0;
    do_reset();

    // Basic shift with latency check.
    step(1'b1, 8'b0001_0110, 3'd3, 1'b1, 8'd10, 4'd1, 1'b1, a);
    check_eq("lat_s0", 64'(valid_out), 64'd0);
    idle(1'b1);
    check_eq("lat_s1", 64'(valid_out), 64'd1);
    check_eq("basic", 64'({data_out, exp_out, shift_out, zero_out}), 64'({8'hB0, 8'd7, 3'd3, 1'b0}));
    idle(1'b1);

    // Zero beat; lzc_in must be ignored.
    step(1'b1, 8'd0, 3'd6, 1'b0, 8'd5, 4'd2, 1'b1, a);
    idle(1'b1);
    check_eq("zero", 64'({data_out, exp_out, shift_out, zero_out, underflow_out}),
             64'({8'd0, 8'd5, 3'd0, 1'b1, 1'b0}));
    idle(1'b1);

    // Underflow.
    step(1'b1, 8'b0000_0100, 3'd5, 1'b1, 8'd2, 4'd3, 1'b1, a);
    idle(1'b1);
    check_eq("underflow", 64'({data_out, exp_out, underflow_out}), 64'({8'h80, 8'hFD, 1'b1}));
    idle(1'b1);

    // Back-pressure: four stalled cycles, then release.
    next_tag = 1;
    pops0 = n_pops;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'($urandom), 3'($urandom), 1'b1, 8'($urandom), 4'(next_tag), 1'b0, a);
      if (c >= 2) check_eq("bp_ready_in", 64'(a), 64'd0);
      if (a) next_tag++;
    end
    check_eq("bp_hold_valid", 64'(valid_out), 64'd1);
    check_eq("bp_hold_tag", 64'(tag_out), 64'd1);
    for (int c = 0; c < 4; c++) begin
      step(next_tag <= 4, 8'($urandom), 3'($urandom), 1'b1, 8'($urandom), 4'(next_tag), 1'b1, a);
      if (a) next_tag++;
    end
    check_eq("bp_pops", 64'(n_pops - pops0), 64'd4);
    check_eq("bp_all_sent", 64'(next_tag), 64'd5);
    idle(1'b1);
    idle(1'b1);

    // Reset with two beats in flight.
    step(1'b1, 8'h11, 3'd1, 1'b1, 8'd9, 4'd7, 1'b0, a);
    step(1'b1, 8'h22, 3'd2, 1'b1, 8'd9, 4'd8, 1'b0, a);
    do_reset();
    step(1'b1, 8'h03, 3'd6, 1'b1, 8'd40, 4'd9, 1'b1, a);
    idle(1'b1);
    check_eq("post_rst_first_tag", 64'(tag_out), 64'd9);
    idle(1'b1);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 4) != 0),
           8'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 7), a);
    end
    for (int c = 0; c < 8; c++) idle(1'b1);
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);

`ifdef NORM_PERF_EN
    check_eq("perf_random", 64'(perf_zero_count), 64'(zero_acc));
    do_reset();
    check_eq("perf_rst", 64'(perf_zero_count), 64'd0);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 8'(c + 1), 3'd1, c >= 4, 8'd20, 4'(c), 1'b1, a);
    end
    for (int c = 0; c < 4; c++) idle(1'b1);
    check_eq("perf_count", 64'(perf_zero_count), 64'd4);
    do_reset();
    check_eq("perf_rst2", 64'(perf_zero_count), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vx_norm_shift.md
VX_NORM_SHIFT -- requirements
Module: VX_norm_shift

Interface
REQ-001 SHALL have parameter N, default 32: data width to normalize, N >= 2.
REQ-002 SHALL have parameter EXPW, default 8: exponent width.
REQ-003 SHALL have parameter TAGW, default 1: pass-through tag width.
REQ-004 SHALL derive LOGN = LOG2UP(N); not overridable.
REQ-005 clk  input  1  clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid_in  input  1  input beat valid.
REQ-008 ready_in  output  1  block can accept an input beat.
REQ-009 data_in  input  N  unnormalized value.
REQ-010 lzc_in  input  LOGN  leading-zero count of data_in from the upstream lzc stage.
REQ-011 lzc_valid_in  input  1  upstream lzc valid flag; 0 means data_in is zero.
REQ-012 exp_in  input  EXPW  unsigned exponent paired with data_in.
REQ-013 tag_in  input  TAGW  opaque tag.
REQ-014 valid_out  output  1  output beat valid.
REQ-015 ready_out  input  1  downstream accepts the output beat.
REQ-016 data_out  output  N  normalized value.
REQ-017 exp_out  output  EXPW  adjusted exponent.
REQ-018 shift_out  output  LOGN  shift amount applied.
REQ-019 zero_out  output  1  input was zero.
REQ-020 underflow_out  output  1  exponent adjustment wrapped below zero.
REQ-021 tag_out  output  TAGW  tag of the output beat.

Function
REQ-022 SHALL be a two-stage pipeline: S0 registers the inputs; S1 registers the shift and exponent result. Latency is exactly 2 cycles with no stall.
REQ-023 Input transfer SHALL occur when valid_in && ready_in; output transfer SHALL occur when valid_out && ready_out.
REQ-024 Each stage SHALL advance when it is empty or its successor advances. ready_in = !S0_valid || S1_advance. This gives full throughput, 1 beat per cycle.
REQ-025 A stalled stage SHALL hold all fields stable; valid_out SHALL NOT drop until the beat is accepted.
REQ-026 Nonzero beat (lzc_valid_in=1):
  - data_out = data_in << lzc_in, truncated to N bits.
  - shift_out = lzc_in.
  - exp_out = (exp_in - lzc_in) mod 2^EXPW.
  - underflow_out = (lzc_in > exp_in), unsigned compare.
  - zero_out = 0.
REQ-027 Zero beat (lzc_valid_in=0): data_out=0, shift_out=0, exp_out=exp_in, underflow_out=0, zero_out=1; lzc_in is ignored.
REQ-028 If lzc_in >= N (possible when N is not a power of two), data_out SHALL be 0. exp_out and underflow_out follow REQ-026.
REQ-029 tag_in SHALL emerge unchanged on tag_out with its beat. Beat order SHALL be preserved.
REQ-030 A simultaneous S1 output transfer and S0 load in the same cycle SHALL lose no beat.

Reset
REQ-031 While reset is high: S0/S1 valid clear, ready_in=0, valid_out=0.
REQ-032 Data, exp, shift, tag and flag registers SHALL reset to 0.
REQ-033 Beats in flight at reset SHALL be discarded and never emitted. The first output after reset SHALL be the first beat accepted after reset.
REQ-034 ready_in SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro NORM_PERF_EN:
  - When defined, add output perf_zero_count (32 bits). It counts zero beats accepted at the input.
  - The counter resets to 0, increments by 1 per accepted zero beat, and saturates at 32'hFFFFFFFF.
  - When undefined, the port and counter are absent and all other behaviour is identical.

Verification
(N=8, EXPW=8 unless stated.)
REQ-036 Basic shift: data_in=8'b0001_0110, lzc_in=3, exp_in=10, valid_in 1 cycle -> 2 cycles later valid_out=1, data_out=8'b1011_0000, exp_out=7, shift_out=3, zero_out=0.
REQ-037 Zero input: data_in=0, lzc_valid_in=0, exp_in=5 -> data_out=0, exp_out=5, shift_out=0, zero_out=1, underflow_out=0.
REQ-038 Underflow: data_in=8'b0000_0100, lzc_in=5, exp_in=2 -> data_out=8'h80, exp_out=8'hFD, underflow_out=1.
REQ-039 Back-pressure: stream tags 1,2,3,4 with ready_out=0 for 4 cycles -> ready_in=0 once S0 and S1 are full. After release: tags 1..4 out in order, one per cycle, none lost or duplicated.
REQ-040 Reset mid-stream: 2 beats in flight, reset high 1 cycle -> valid_out=0 next cycle. The next output is a post-reset beat.
REQ-041 Perf counter (NORM_PERF_EN defined): accept 4 zero beats and 3 nonzero beats -> perf_zero_count=4. After reset, perf_zero_count=0.
